// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures high/low clk-cycle counts of each period of an incoming PWM signal
// Optional deglitcher after the synchroniser: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] high_cnt,
  output logic [WIDTH-1:0] low_cnt,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_sat;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [WIDTH-1:0]       r_cnt;
  logic [WIDTH-1:0]       w_cnt_nxt;
  logic [WIDTH-1:0]       r_hi_tmp;
  logic [WIDTH-1:0]       w_hi_tmp_nxt;
  logic [WIDTH-1:0]       r_high_cnt;
  logic [WIDTH-1:0]       w_high_cnt_nxt;
  logic [WIDTH-1:0]       r_low_cnt;
  logic [WIDTH-1:0]       w_low_cnt_nxt;
  logic                   r_valid;
  logic                   w_valid_nxt;
  logic                   r_timeout;
  logic                   w_timeout_nxt;
  logic                   r_busy;
  logic                   w_busy_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic r_filt;

  // The last two synchroniser flops must agree before the filtered level moves,
  // so a single-cycle pulse never reaches the edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt <= 1'b0;
    end else if (r_sync[SYNC_STAGES-1] == r_sync[SYNC_STAGES-2]) begin
      r_filt <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_s = r_filt;
`else
  assign w_s = r_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s_d <= 1'b0;
    end else begin
      r_s_d <= w_s;
    end
  end

  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;
  assign w_sat  = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_ARM;
        ST_ARM:  if (w_rise) w_state_nxt = ST_HIGH;
        ST_HIGH: begin
          if (w_fall)     w_state_nxt = ST_LOW;
          else if (w_sat) w_state_nxt = ST_ARM;
        end
        ST_LOW: begin
          if (w_rise)     w_state_nxt = ST_HIGH;
          else if (w_sat) w_state_nxt = ST_ARM;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // An edge is checked before saturation so a level of exactly CNT_MAX cycles is still reported.
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_hi_tmp_nxt   = r_hi_tmp;
    w_high_cnt_nxt = r_high_cnt;
    w_low_cnt_nxt  = r_low_cnt;
    w_valid_nxt    = 1'b0;
    w_timeout_nxt  = 1'b0;
    if (!enable) begin
      w_cnt_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: w_cnt_nxt = '0;
        ST_ARM:  if (w_rise) w_cnt_nxt = CNT_ONE;
        ST_HIGH: begin
          if (w_fall) begin
            w_hi_tmp_nxt = r_cnt;
            w_cnt_nxt    = CNT_ONE;
          end else if (w_sat) begin
            w_timeout_nxt = 1'b1;
            w_cnt_nxt     = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            w_high_cnt_nxt = r_hi_tmp;
            w_low_cnt_nxt  = r_cnt;
            w_valid_nxt    = 1'b1;
            w_cnt_nxt      = CNT_ONE;
          end else if (w_sat) begin
            w_timeout_nxt = 1'b1;
            w_cnt_nxt     = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: w_cnt_nxt = '0;
      endcase
    end
  end

  assign w_busy_nxt = (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_LOW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_hi_tmp   <= '0;
      r_high_cnt <= '0;
      r_low_cnt  <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_hi_tmp   <= w_hi_tmp_nxt;
      r_high_cnt <= w_high_cnt_nxt;
      r_low_cnt  <= w_low_cnt_nxt;
      r_valid    <= w_valid_nxt;
      r_timeout  <= w_timeout_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign high_cnt = r_high_cnt;
  assign low_cnt  = r_low_cnt;
  assign valid    = r_valid;
  assign timeout  = r_timeout;
  assign busy     = r_busy;

endmodule
